hs_pipe_slice: RTL and testbench

- Parametrised valid/ready register slice chain; next-generation replacement for the fixed 16-bit single-mode pipeline units.
- Width, stage count and register mode are selected per instance.
- Provides a synchronous flush and an idle indication.
- Inserted on any valid/ready stream crossing a timing-critical path: bus fabrics, DMA read/write channels, inter-block links.

---
 rtl/hs_pipe_slice.sv | 207 ++++++++++++++++++++
 tb/tb_hs_pipe_slice.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_pipe_slice.sv
// ============================================================================
// Module   : hs_pipe_slice
// Brief    : Parametrised valid/ready register slice chain (bypass, forward,
//            backward/skid, full) with synchronous flush and idle indication.
//            Optional counters enabled by defining HS_PIPE_SLICE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_pipe_slice #(
    parameter int DATA_W = 16,
    parameter int STAGES = 1,
    parameter int MODE   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_up,
    input  logic [DATA_W-1:0] data_up,
    output logic              ready_up,
    output logic              valid_down,
    output logic [DATA_W-1:0] data_down,
    input  logic              ready_down,
    output logic              idle
`ifdef HS_PIPE_SLICE_STATS_EN
    ,
    output logic [31:0]       xfer_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    generate
        if (MODE == 0) begin : g_bypass
            assign ready_up   = ready_down;
            assign valid_down = valid_up;
            assign data_down  = data_up;
            assign idle       = 1'b1;
        end else begin : g_chain
            // Index s is the interface feeding stage s; index STAGES is the chain output.
            logic              w_vld [0:STAGES];
            logic              w_rdy [0:STAGES];
            logic [DATA_W-1:0] w_dat [0:STAGES];
            logic [STAGES-1:0] w_empty;

            assign w_vld[0]      = valid_up;
            assign w_dat[0]      = data_up;
            assign w_rdy[STAGES] = ready_down;
            assign ready_up      = w_rdy[0];
            assign valid_down    = w_vld[STAGES];
            assign data_down     = w_dat[STAGES];
            assign idle          = &w_empty;

            for (genvar s = 0; s < STAGES; s++) begin : g_stage
                if (MODE == 1) begin : g_fwd
                    logic              r_full;
                    logic [DATA_W-1:0] r_data;
                    logic              w_push;
                    logic              w_pop;

                    assign w_rdy[s]   = !r_full || w_rdy[s+1];
                    assign w_push     = w_vld[s] && w_rdy[s];
                    assign w_pop      = r_full && w_rdy[s+1];
                    assign w_vld[s+1] = r_full;
                    assign w_dat[s+1] = r_data;
                    assign w_empty[s] = !r_full;

                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            r_full <= 1'b0;
                            r_data <= '0;
                        end else if (flush) begin
                            r_full <= 1'b0;
                            r_data <= '0;
                        end else if (w_push) begin
                            r_full <= 1'b1;
                            r_data <= w_dat[s];
                        end else if (w_pop) begin
                            r_full <= 1'b0;
                            r_data <= '0;
                        end
                    end
                end else if (MODE == 2) begin : g_skid
                    logic              r_full;
                    logic [DATA_W-1:0] r_data;

                    // Pass-through is suppressed in reset and during flush so no beat escapes.
                    assign w_rdy[s]   = !r_full;
                    assign w_vld[s+1] = r_full || (w_vld[s] && rst && !flush);
                    assign w_dat[s+1] = r_full ? r_data : (rst ? w_dat[s] : '0);
                    assign w_empty[s] = !r_full;

                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            r_full <= 1'b0;
                            r_data <= '0;
                        end else if (flush) begin
                            r_full <= 1'b0;
                            r_data <= '0;
                        end else if (!r_full && w_vld[s] && !w_rdy[s+1]) begin
                            r_full <= 1'b1;
                            r_data <= w_dat[s];
                        end else if (r_full && w_rdy[s+1]) begin
                            r_full <= 1'b0;
                            r_data <= '0;
                        end
                    end
                end else begin : g_full
                    state_t            r_st;
                    logic              r_rdy;
                    logic [DATA_W-1:0] r_out;
                    logic [DATA_W-1:0] r_skid;
                    logic              w_push;
                    logic              w_pop;

                    assign w_rdy[s]   = r_rdy;
                    assign w_push     = w_vld[s] && r_rdy;
                    assign w_pop      = (r_st != ST_EMPTY) && w_rdy[s+1];
                    assign w_vld[s+1] = (r_st != ST_EMPTY);
                    assign w_dat[s+1] = r_out;
                    assign w_empty[s] = (r_st == ST_EMPTY);

                    // r_out always holds the oldest beat; r_skid the newer one when FULL.
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            r_st   <= ST_EMPTY;
                            r_rdy  <= 1'b1;
                            r_out  <= '0;
                            r_skid <= '0;
                        end else if (flush) begin
                            r_st   <= ST_EMPTY;
                            r_rdy  <= 1'b1;
                            r_out  <= '0;
                            r_skid <= '0;
                        end else begin
                            case (r_st)
                                ST_EMPTY: begin
                                    if (w_push) begin
                                        r_out <= w_dat[s];
                                        r_st  <= ST_HALF;
                                    end
                                end
                                ST_HALF: begin
                                    if (w_push && !w_pop) begin
                                        r_skid <= w_dat[s];
                                        r_st   <= ST_FULL;
                                        r_rdy  <= 1'b0;
                                    end else if (!w_push && w_pop) begin
                                        r_out <= '0;
                                        r_st  <= ST_EMPTY;
                                    end else if (w_push && w_pop) begin
                                        r_out <= w_dat[s];
                                    end
                                end
                                ST_FULL: begin
                                    if (w_pop) begin
                                        r_out  <= r_skid;
                                        r_skid <= '0;
                                        r_st   <= ST_HALF;
                                        r_rdy  <= 1'b1;
                                    end
                                end
                                default: begin
                                    r_st  <= ST_EMPTY;
                                    r_rdy <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end
        end
    endgenerate

`ifdef HS_PIPE_SLICE_STATS_EN
    logic [31:0] r_xfer;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xfer  <= '0;
            r_stall <= '0;
        end else if (flush) begin
            r_xfer  <= '0;
            r_stall <= '0;
        end else begin
            if (valid_down && ready_down && !(&r_xfer)) begin
                r_xfer <= r_xfer + 32'd1;
            end
            if (valid_down && !ready_down && !(&r_stall)) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign xfer_cnt  = r_xfer;
    assign stall_cnt = r_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hs_pipe_slice.sv
// ============================================================================
// Module   : tb_hs_pipe_slice
// Brief    : Self-checking bench for hs_pipe_slice across all register modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs_pipe_slice;

    localparam int N = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        vu  [N];
    logic [63:0] du  [N];
    logic        rd  [N];
    logic        ru  [N];
    logic        vd  [N];
    logic [63:0] dd  [N];
    logic        idl [N];
`ifdef HS_PIPE_SLICE_STATS_EN
    logic [31:0] xc  [N];
    logic [31:0] sc  [N];
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    // Instance g: 0 bypass, 1 forward x3, 2 skid x1, 3 full x2, 4 full x2 at 64 bits.
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W  = (g == 4) ? 64 : 16;
        localparam int MD = (g == 4) ? 3 : g;
        localparam int ST = (g == 1) ? 3 : ((g >= 3) ? 2 : 1);
        logic         w_ru;
        logic         w_vd;
        logic         w_idle;
        logic [W-1:0] w_dd;
`ifdef HS_PIPE_SLICE_STATS_EN
        logic [31:0]  w_xc;
        logic [31:0]  w_sc;
`endif
        hs_pipe_slice #(.DATA_W(W), .STAGES(ST), .MODE(MD)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .valid_up   (vu[g]),
            .data_up    (du[g][W-1:0]),
            .ready_up   (w_ru),
            .valid_down (w_vd),
            .data_down  (w_dd),
            .ready_down (rd[g]),
            .idle       (w_idle)
`ifdef HS_PIPE_SLICE_STATS_EN
            ,
            .xfer_cnt   (w_xc),
            .stall_cnt  (w_sc)
`endif
        );
        assign ru[g]  = w_ru;
        assign vd[g]  = w_vd;
        assign idl[g] = w_idle;
        assign dd[g]  = 64'(w_dd);
`ifdef HS_PIPE_SLICE_STATS_EN
        assign xc[g]  = w_xc;
        assign sc[g]  = w_sc;
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            vu[i] = 1'b0;
            du[i] = '0;
            rd[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        rd[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (vd[i] !== 1'b0 || dd[i] !== 64'd0 || idl[i] !== 1'b1) begin
                failures++;
                $display("FAIL reset_state[%0d]: got v=%b d=%h idle=%b required v=0 d=0 idle=1", i, vd[i], dd[i], idl[i]);
            end
            checks++;
            if (ru[i] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready[%0d]: got %b required 1", i, ru[i]);
            end
        end
        step();
        rst = 1'b1;
        rd[0] = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        vu[0] = 1'b1;
        du[0] = 64'h1234;
        rd[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (vd[0] !== 1'b1 || dd[0] !== 64'h1234 || ru[0] !== 1'b0 || idl[0] !== 1'b1) begin
            failures++;
            $display("FAIL bypass_wires: got v=%b d=%h r=%b idle=%b required v=1 d=1234 r=0 idle=1", vd[0], dd[0], ru[0], idl[0]);
        end
        rd[0] = 1'b1;
        #1;
        checks++;
        if (ru[0] !== 1'b1) begin
            failures++;
            $display("FAIL bypass_ready: got %b required 1", ru[0]);
        end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_fwd_latency();
        logic [63:0] e;
        sb.delete();
        rd[1] = 1'b1;
        for (int c = 0; c < 13; c++) begin
            vu[1] = (c < 8);
            du[1] = (c < 8) ? 64'(c + 1) : 64'd0;
            @(negedge clk);
            if (vu[1] && ru[1]) sb.push_back(du[1]);
            checks++;
            if (vd[1] !== (c >= 3 && c <= 10)) begin
                failures++;
                $display("FAIL fwd_valid_cycle%0d: got %b required %b", c, vd[1], (c >= 3 && c <= 10));
            end
            if (vd[1] === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL fwd_extra_beat: got %h required none", dd[1]);
                end else begin
                    e = sb.pop_front();
                    if (dd[1] !== e) begin
                        failures++;
                        $display("FAIL fwd_data_cycle%0d: got %h required %h", c, dd[1], e);
                    end
                end
            end
            if (c == 12) begin
                checks++;
                if (idl[1] !== 1'b1 || sb.size() != 0) begin
                    failures++;
                    $display("FAIL fwd_idle: got idle=%b left=%0d required idle=1 left=0", idl[1], sb.size());
                end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_skid();
        logic [63:0] e;
        sb.delete();
        vu[2] = 1'b1;
        du[2] = 64'hA5A5;
        rd[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (ru[2] !== 1'b1 || vd[2] !== 1'b1 || dd[2] !== 64'hA5A5) begin
            failures++;
            $display("FAIL skid_pass: got r=%b v=%b d=%h required r=1 v=1 d=a5a5", ru[2], vd[2], dd[2]);
        end
        if (vu[2] && ru[2]) sb.push_back(du[2]);
        step();
        vu[2] = 1'b0;
        du[2] = 64'h0;
        @(negedge clk);
        checks++;
        if (ru[2] !== 1'b0 || vd[2] !== 1'b1 || dd[2] !== 64'hA5A5) begin
            failures++;
            $display("FAIL skid_held: got r=%b v=%b d=%h required r=0 v=1 d=a5a5", ru[2], vd[2], dd[2]);
        end
        step();
        rd[2] = 1'b1;
        @(negedge clk);
        checks++;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hFFFF_FFFF;
        if (vd[2] !== 1'b1 || dd[2] !== e || ru[2] !== 1'b0) begin
            failures++;
            $display("FAIL skid_drain: got v=%b d=%h r=%b required v=1 d=%h r=0", vd[2], dd[2], ru[2], e);
        end
        step();
        @(negedge clk);
        checks++;
        if (ru[2] !== 1'b1 || vd[2] !== 1'b0 || idl[2] !== 1'b1) begin
            failures++;
            $display("FAIL skid_recover: got r=%b v=%b idle=%b required r=1 v=0 idle=1", ru[2], vd[2], idl[2]);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_full_fill();
        int          acc = 0;
        logic [63:0] e;
        sb.delete();
        rd[3] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vu[3] = 1'b1;
            du[3] = 64'(16'h0010 + acc);
            @(negedge clk);
            if (ru[3]) begin
                sb.push_back(du[3]);
                acc++;
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (acc != 4 || ru[3] !== 1'b0) begin
            failures++;
            $display("FAIL full_capacity: got accepted=%0d r=%b required accepted=4 r=0", acc, ru[3]);
        end
        step();
        vu[3] = 1'b0;
        rd[3] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (vd[3] !== (c < 4)) begin
                failures++;
                $display("FAIL full_drain_valid%0d: got %b required %b", c, vd[3], (c < 4));
            end
            if (vd[3] === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (dd[3] !== e) begin
                    failures++;
                    $display("FAIL full_drain_data%0d: got %h required %h", c, dd[3], e);
                end
            end
            step();
        end
        checks++;
        if (idl[3] !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL full_idle: got idle=%b left=%0d required idle=1 left=0", idl[3], sb.size());
        end
        clear_inputs();
    endtask

    task automatic load_beats(input int m, input int nb);
        rd[m] = 1'b0;
        for (int k = 0; k < nb; k++) begin
            vu[m] = 1'b1;
            du[m] = 64'(16'h0A00 + k);
            @(negedge clk);
            checks++;
            if (ru[m] !== 1'b1) begin
                failures++;
                $display("FAIL load_ready[%0d]: got %b required 1", m, ru[m]);
            end
            step();
        end
        vu[m] = 1'b0;
    endtask

    task automatic test_flush();
        for (int m = 1; m <= 3; m++) begin
            load_beats(m, (m == 2) ? 1 : 2);
            step();
            step();
            flush = 1'b1;
            vu[m] = 1'b1;
            du[m] = 64'hBEEF;
            step();
            flush = 1'b0;
            vu[m] = 1'b0;
            du[m] = 64'h0;
            @(negedge clk);
            checks++;
            if (vd[m] !== 1'b0 || idl[m] !== 1'b1 || dd[m] !== 64'd0) begin
                failures++;
                $display("FAIL flush_empty[%0d]: got v=%b idle=%b d=%h required v=0 idle=1 d=0", m, vd[m], idl[m], dd[m]);
            end
            rd[m] = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                checks++;
                if (vd[m] !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_leak[%0d]: got v=%b d=%h required v=0", m, vd[m], dd[m]);
                end
                step();
            end
            clear_inputs();
        end
    endtask

    task automatic test_async_reset();
        for (int m = 1; m <= 3; m++) begin
            vu[m] = 1'b1;
            du[m] = 64'h0C00;
            rd[m] = 1'b0;
        end
        step();
        step();
        for (int m = 1; m <= 3; m++) vu[m] = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        for (int m = 1; m <= 3; m++) begin
            checks++;
            if (vd[m] !== 1'b0 || dd[m] !== 64'd0 || idl[m] !== 1'b1 || ru[m] !== 1'b1) begin
                failures++;
                $display("FAIL async_reset[%0d]: got v=%b d=%h idle=%b r=%b required v=0 d=0 idle=1 r=1", m, vd[m], dd[m], idl[m], ru[m]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic random_run(input int m, input int n, input int budget);
        int          got  = 0;
        int          cyc  = 0;
        logic        hold = 1'b0;
        logic        pv   = 1'b0;
        logic        prd  = 1'b0;
        logic [63:0] pd   = '0;
        logic [63:0] mask;
        logic [63:0] e;
        mask = (m == 4) ? {64{1'b1}} : 64'h0000_0000_0000_FFFF;
        sb.delete();
        while (got < n && cyc < budget) begin
            if (!hold) begin
                vu[m] = 1'($urandom_range(0, 1));
                du[m] = {$urandom(), $urandom()} & mask;
            end
            rd[m] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (pv && !prd) begin
                checks++;
                if (vd[m] !== 1'b1 || dd[m] !== pd) begin
                    failures++;
                    $display("FAIL rand_stable[%0d]: got v=%b d=%h required v=1 d=%h", m, vd[m], dd[m], pd);
                end
            end
            if (vu[m] && ru[m]) sb.push_back(du[m]);
            hold = vu[m] && !ru[m];
            if (vd[m] && rd[m]) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra[%0d]: got %h required none", m, dd[m]);
                end else begin
                    e = sb.pop_front();
                    if (dd[m] !== e) begin
                        failures++;
                        $display("FAIL rand_order[%0d]: got %h required %h", m, dd[m], e);
                    end
                end
            end
            pv  = vd[m];
            prd = rd[m];
            pd  = dd[m];
            step();
            cyc++;
        end
        checks++;
        if (got < n) begin
            failures++;
            $display("FAIL rand_timeout[%0d]: got %0d beats required %0d", m, got, n);
        end
        vu[m] = 1'b0;
        rd[m] = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (vd[m] && sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (dd[m] !== e) begin
                    failures++;
                    $display("FAIL rand_drain[%0d]: got %h required %h", m, dd[m], e);
                end
            end
            step();
        end
        checks++;
        if (sb.size() != 0 || idl[m] !== 1'b1) begin
            failures++;
            $display("FAIL rand_lost[%0d]: got left=%0d idle=%b required left=0 idle=1", m, sb.size(), idl[m]);
        end
        clear_inputs();
    endtask

`ifdef HS_PIPE_SLICE_STATS_EN
    task automatic test_stats();
        int w = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        rd[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vu[1] = 1'b1;
            du[1] = 64'(k + 1);
            step();
        end
        vu[1] = 1'b0;
        repeat (5) step();
        @(negedge clk);
        checks++;
        if (xc[1] !== 32'd5 || sc[1] !== 32'd0) begin
            failures++;
            $display("FAIL stats_xfer: got x=%0d s=%0d required x=5 s=0", xc[1], sc[1]);
        end
        rd[1] = 1'b0;
        vu[1] = 1'b1;
        du[1] = 64'h77;
        step();
        vu[1] = 1'b0;
        @(negedge clk);
        while (vd[1] !== 1'b1 && w < 10) begin
            step();
            @(negedge clk);
            w++;
        end
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (xc[1] !== 32'd5 || sc[1] !== 32'd3) begin
            failures++;
            $display("FAIL stats_stall: got x=%0d s=%0d required x=5 s=3", xc[1], sc[1]);
        end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (xc[1] !== 32'd0 || sc[1] !== 32'd0) begin
            failures++;
            $display("FAIL stats_flush: got x=%0d s=%0d required x=0 s=0", xc[1], sc[1]);
        end
        step();
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_fwd_latency();
        test_skid();
        test_full_fill();
        test_flush();
        test_async_reset();
`ifdef HS_PIPE_SLICE_STATS_EN
        test_stats();
`endif
        random_run(4, 10000, 50000);
        random_run(0, 300, 3000);
        random_run(1, 300, 3000);
        random_run(2, 300, 3000);
        random_run(3, 300, 3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
